// File: rtl/l2d_port_arbiter_pkg.sv
// Shared widths, op/state encodings and the op-priority helper for the L2d port arbiter.
package main_memory_config;
    localparam int MAIN_MEMORY_DATA_WIDTH = 128;
endpackage

package cache_config;
    localparam int ADDRESS_WIDTH = 32;
    localparam int DATA_WIDTH    = 32;

    typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE, OP_WB} op_e;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    // Write-back outranks write-word, which outranks read.
    function automatic op_e pick_op(input logic wb, input logic wr, input logic rd);
        if (wb) begin
            return OP_WB;
        end else if (wr) begin
            return OP_WRITE;
        end else if (rd) begin
            return OP_READ;
        end
        return OP_NONE;
    endfunction
endpackage

// File: rtl/l2d_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index after i_last, wrapping to 0.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_eligible,
    input  logic [IW-1:0] i_last,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [IW-1:0] w_cand;

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int i = 1; i <= N; i++) begin
            w_cand = IW'((int'(i_last) + i) % N);
            if (!o_valid && i_eligible[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/l2d_port_arbiter.sv
// Arbitrates NUM_REQ L1d requesters onto the single L2d port, one transaction at a time,
// with round-robin fairness, fixed op priority and an abort after TIMEOUT wait cycles.
module l2d_port_arbiter
    import cache_config::*;
    import main_memory_config::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_REQ-1:0]                         req_read,
    input  logic [NUM_REQ-1:0]                         req_write,
    input  logic [NUM_REQ-1:0]                         req_wb,
    input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0]      req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]         req_wdata,
    input  logic [NUM_REQ-1:0][MAIN_MEMORY_DATA_WIDTH-1:0] req_wbdata,
    output logic [NUM_REQ-1:0]                         gnt,
    output logic [NUM_REQ-1:0]                         done,
    output logic                                       err,
    output logic [MAIN_MEMORY_DATA_WIDTH-1:0]          rdata,
    output logic                                       l2_read_req,
    output logic                                       l2_write_req,
    output logic                                       l2_wb_req,
    output logic [ADDRESS_WIDTH-1:0]                   l2_addr,
    output logic [DATA_WIDTH-1:0]                      l2_wdata,
    output logic [MAIN_MEMORY_DATA_WIDTH-1:0]          l2_wbdata,
    input  logic                                       l2_ready,
    input  logic                                       l2_write_verified,
    input  logic                                       l2_wb_verified,
    input  logic [MAIN_MEMORY_DATA_WIDTH-1:0]          l2_rdata
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_COUNT   = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] RESET_WINNER = IW'(NUM_REQ - 1);

    state_e                            r_state,      w_nextState;
    op_e                               r_op,         w_op;
    logic [IW-1:0]                     r_idx,        w_idx;
    logic [IW-1:0]                     r_lastWinner, w_lastWinner;
    logic [CW-1:0]                     r_count,      w_count;
    logic [NUM_REQ-1:0]                r_gnt,        w_gnt;
    logic [NUM_REQ-1:0]                r_done,       w_done;
    logic                              r_err,        w_err;
    logic [2:0]                        r_l2Req,      w_l2Req;
    logic [ADDRESS_WIDTH-1:0]          r_addr,       w_addr;
    logic [DATA_WIDTH-1:0]             r_wdata,      w_wdata;
    logic [MAIN_MEMORY_DATA_WIDTH-1:0] r_wbdata,     w_wbdata;
    logic [MAIN_MEMORY_DATA_WIDTH-1:0] r_rdata,      w_rdata;

    logic [NUM_REQ-1:0] w_eligible;
    logic [IW-1:0]      w_pickIdx;
    logic               w_pickValid;
    logic               w_complete;

    assign w_eligible = req_read | req_write | req_wb;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
        .i_eligible (w_eligible),
        .i_last     (r_lastWinner),
        .o_idx      (w_pickIdx),
        .o_valid    (w_pickValid)
    );

    // Only the completion strobe belonging to the latched op ends the transaction.
    assign w_complete = ((r_op == OP_READ)  && l2_ready)          ||
                        ((r_op == OP_WRITE) && l2_write_verified) ||
                        ((r_op == OP_WB)    && l2_wb_verified);

    always_comb begin
        w_nextState  = r_state;
        w_op         = r_op;
        w_idx        = r_idx;
        w_lastWinner = r_lastWinner;
        w_count      = r_count;
        w_gnt        = r_gnt;
        w_done       = '0;
        w_err        = 1'b0;
        w_l2Req      = r_l2Req;
        w_addr       = r_addr;
        w_wdata      = r_wdata;
        w_wbdata     = r_wbdata;
        w_rdata      = r_rdata;
        case (r_state)
            IDLE: begin
                if (w_pickValid) begin
                    w_idx       = w_pickIdx;
                    w_op        = pick_op(req_wb[w_pickIdx], req_write[w_pickIdx],
                                          req_read[w_pickIdx]);
                    w_addr      = req_addr[w_pickIdx];
                    w_wdata     = req_wdata[w_pickIdx];
                    w_wbdata    = req_wbdata[w_pickIdx];
                    w_gnt       = NUM_REQ'(1) << w_pickIdx;
                    w_l2Req     = {w_op == OP_READ, w_op == OP_WRITE, w_op == OP_WB};
                    w_count     = '0;
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                if (w_complete || (r_count == LAST_COUNT)) begin
                    w_err        = !w_complete;
                    w_done       = r_gnt;
                    w_l2Req      = '0;
                    w_lastWinner = r_idx;
                    if ((r_op == OP_READ) && l2_ready) begin
                        w_rdata = l2_rdata;
                    end
                    w_nextState  = DONE;
                end else begin
                    w_count = r_count + 1'b1;
                end
            end
            DONE: begin
                w_gnt       = '0;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_op         <= OP_NONE;
            r_idx        <= '0;
            r_lastWinner <= RESET_WINNER;
            r_count      <= '0;
            r_gnt        <= '0;
            r_done       <= '0;
            r_err        <= 1'b0;
            r_l2Req      <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wbdata     <= '0;
            r_rdata      <= '0;
        end else begin
            r_state      <= w_nextState;
            r_op         <= w_op;
            r_idx        <= w_idx;
            r_lastWinner <= w_lastWinner;
            r_count      <= w_count;
            r_gnt        <= w_gnt;
            r_done       <= w_done;
            r_err        <= w_err;
            r_l2Req      <= w_l2Req;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_wbdata     <= w_wbdata;
            r_rdata      <= w_rdata;
        end
    end

    assign gnt          = r_gnt;
    assign done         = r_done;
    assign err          = r_err;
    assign rdata        = r_rdata;
    assign l2_read_req  = r_l2Req[2];
    assign l2_write_req = r_l2Req[1];
    assign l2_wb_req    = r_l2Req[0];
    assign l2_addr      = r_addr;
    assign l2_wdata     = r_wdata;
    assign l2_wbdata    = r_wbdata;

endmodule

// File: tb/tb_l2d_port_arbiter.sv
// Self-checking bench for l2d_port_arbiter: directed scenarios plus randomized
// transactions compared against a round-robin/priority reference model.
module tb_l2d_port_arbiter;
    import cache_config::*;
    import main_memory_config::*;

    localparam int NREQ = 4;
    localparam int TMO  = 8;
    localparam int AW   = ADDRESS_WIDTH;
    localparam int DW   = DATA_WIDTH;
    localparam int MW   = MAIN_MEMORY_DATA_WIDTH;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NREQ-1:0]          reqRead, reqWrite, reqWb;
    logic [NREQ-1:0][AW-1:0]  reqAddr;
    logic [NREQ-1:0][DW-1:0]  reqWdata;
    logic [NREQ-1:0][MW-1:0]  reqWbdata;
    logic [NREQ-1:0]          gnt, done;
    logic                     err;
    logic [MW-1:0]            rdata;
    logic                     l2ReadReq, l2WriteReq, l2WbReq;
    logic [AW-1:0]            l2Addr;
    logic [DW-1:0]            l2Wdata;
    logic [MW-1:0]            l2Wbdata;
    logic                     l2Ready, l2WriteVerified, l2WbVerified;
    logic [MW-1:0]            l2Rdata;

    int compared   = 0;
    int mismatched = 0;

    l2d_port_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_read          (reqRead),
        .req_write         (reqWrite),
        .req_wb            (reqWb),
        .req_addr          (reqAddr),
        .req_wdata         (reqWdata),
        .req_wbdata        (reqWbdata),
        .gnt               (gnt),
        .done              (done),
        .err               (err),
        .rdata             (rdata),
        .l2_read_req       (l2ReadReq),
        .l2_write_req      (l2WriteReq),
        .l2_wb_req         (l2WbReq),
        .l2_addr           (l2Addr),
        .l2_wdata          (l2Wdata),
        .l2_wbdata         (l2Wbdata),
        .l2_ready          (l2Ready),
        .l2_write_verified (l2WriteVerified),
        .l2_wb_verified    (l2WbVerified),
        .l2_rdata          (l2Rdata)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after each rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs;
        reqRead = '0; reqWrite = '0; reqWb = '0;
        reqAddr = '0; reqWdata = '0; reqWbdata = '0;
        l2Ready = 1'b0; l2WriteVerified = 1'b0; l2WbVerified = 1'b0;
        l2Rdata = '0;
    endtask

    task automatic doReset;
        reset = 1'b1;
        clearInputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        clearInputs();
        tick();
        compared++;
        if (gnt !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); end
        compared++;
        if (done !== 4'b0000 || err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done_err: got %b/%b expected 0000/0", done, err); end
        compared++;
        if ({l2ReadReq, l2WriteReq, l2WbReq} !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_l2req: got %b expected 000", {l2ReadReq, l2WriteReq, l2WbReq}); end
        compared++;
        if (l2Addr !== '0 || l2Wdata !== '0 || l2Wbdata !== '0 || rdata !== '0) begin
            mismatched++; $display("[TB] FAIL reset_data: got addr %h wdata %h wbdata %h rdata %h expected all 0", l2Addr, l2Wdata, l2Wbdata, rdata);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_read_basic;
        logic [MW-1:0] line;
        line = {16{8'hAA}};
        doReset();
        reqRead = 4'b0001;
        reqAddr[0] = 32'hC000_0040;
        tick();
        compared++;
        if (gnt !== 4'b0001) begin mismatched++; $display("[TB] FAIL read_gnt: got %b expected 0001", gnt); end
        compared++;
        if ({l2ReadReq, l2WriteReq, l2WbReq} !== 3'b100) begin mismatched++; $display("[TB] FAIL read_l2req: got %b expected 100", {l2ReadReq, l2WriteReq, l2WbReq}); end
        compared++;
        if (l2Addr !== 32'hC000_0040) begin mismatched++; $display("[TB] FAIL read_addr: got %h expected c0000040", l2Addr); end
        tick();
        tick();
        compared++;
        if (done !== 4'b0000) begin mismatched++; $display("[TB] FAIL read_early_done: got %b expected 0000", done); end
        l2Ready = 1'b1;
        l2Rdata = line;
        tick();
        l2Ready = 1'b0;
        l2Rdata = '0;
        compared++;
        if (done !== 4'b0001 || err !== 1'b0) begin mismatched++; $display("[TB] FAIL read_done: got %b/%b expected 0001/0", done, err); end
        compared++;
        if (rdata !== line) begin mismatched++; $display("[TB] FAIL read_rdata: got %h expected %h", rdata, line); end
        compared++;
        if (gnt !== 4'b0001 || {l2ReadReq, l2WriteReq, l2WbReq} !== 3'b000) begin
            mismatched++; $display("[TB] FAIL read_done_cycle: got gnt %b l2req %b expected 0001/000", gnt, {l2ReadReq, l2WriteReq, l2WbReq});
        end
        reqRead = '0;
        tick();
        compared++;
        if (gnt !== 4'b0000 || done !== 4'b0000) begin mismatched++; $display("[TB] FAIL read_release: got gnt %b done %b expected 0000/0000", gnt, done); end
    endtask

    task automatic test_round_robin;
        int waited;
        logic [NREQ-1:0] expGnt;
        doReset();
        reqRead = 4'b1111;
        l2Ready = 1'b1;
        l2Rdata = {$urandom, $urandom, $urandom, $urandom};
        for (int g = 0; g < 5; g++) begin
            waited = 0;
            while (gnt == 4'b0000 && waited < 10) begin tick(); waited++; end
            expGnt = 4'b0001 << (g % NREQ);
            compared++;
            if (gnt !== expGnt) begin mismatched++; $display("[TB] FAIL rr_grant_%0d: got %b expected %b", g, gnt, expGnt); end
            waited = 0;
            while (gnt != 4'b0000 && waited < 10) begin tick(); waited++; end
            compared++;
            if (gnt !== 4'b0000) begin mismatched++; $display("[TB] FAIL rr_release_%0d: got %b expected 0000", g, gnt); end
        end
        reqRead = '0;
        l2Ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_priority;
        logic [MW-1:0] line, rline;
        logic [AW-1:0] addr;
        line  = {$urandom, $urandom, $urandom, $urandom};
        rline = {$urandom, $urandom, $urandom, $urandom};
        addr  = $urandom;
        doReset();
        reqWb = 4'b0100;
        reqRead = 4'b0100;
        reqAddr[2] = addr;
        reqWbdata[2] = line;
        tick();
        compared++;
        if (gnt !== 4'b0100 || {l2ReadReq, l2WriteReq, l2WbReq} !== 3'b001) begin
            mismatched++; $display("[TB] FAIL prio_wb_first: got gnt %b l2req %b expected 0100/001", gnt, {l2ReadReq, l2WriteReq, l2WbReq});
        end
        compared++;
        if (l2Wbdata !== line || l2Addr !== addr) begin mismatched++; $display("[TB] FAIL prio_wb_payload: got %h@%h expected %h@%h", l2Wbdata, l2Addr, line, addr); end
        l2WbVerified = 1'b1;
        tick();
        l2WbVerified = 1'b0;
        reqWb = '0;
        compared++;
        if (done !== 4'b0100 || err !== 1'b0) begin mismatched++; $display("[TB] FAIL prio_wb_done: got %b/%b expected 0100/0", done, err); end
        tick();
        compared++;
        if (gnt !== 4'b0000) begin mismatched++; $display("[TB] FAIL prio_gap: got %b expected 0000", gnt); end
        tick();
        compared++;
        if (gnt !== 4'b0100 || {l2ReadReq, l2WriteReq, l2WbReq} !== 3'b100) begin
            mismatched++; $display("[TB] FAIL prio_read_later: got gnt %b l2req %b expected 0100/100", gnt, {l2ReadReq, l2WriteReq, l2WbReq});
        end
        l2Ready = 1'b1;
        l2Rdata = rline;
        tick();
        l2Ready = 1'b0;
        reqRead = '0;
        compared++;
        if (done !== 4'b0100 || rdata !== rline) begin mismatched++; $display("[TB] FAIL prio_read_done: got %b rdata %h expected 0100 %h", done, rdata, rline); end
        tick();
    endtask

    task automatic test_wrong_completion;
        logic [MW-1:0] rline;
        rline = {$urandom, $urandom, $urandom, $urandom};
        doReset();
        reqRead = 4'b0010;
        reqAddr[1] = $urandom;
        tick();
        l2WriteVerified = 1'b1;
        l2WbVerified = 1'b1;
        tick();
        l2WriteVerified = 1'b0;
        l2WbVerified = 1'b0;
        compared++;
        if (done !== 4'b0000 || {l2ReadReq, l2WriteReq, l2WbReq} !== 3'b100) begin
            mismatched++; $display("[TB] FAIL wrong_cpl_ignored: got done %b l2req %b expected 0000/100", done, {l2ReadReq, l2WriteReq, l2WbReq});
        end
        l2Ready = 1'b1;
        l2Rdata = rline;
        tick();
        l2Ready = 1'b0;
        reqRead = '0;
        compared++;
        if (done !== 4'b0010 || err !== 1'b0 || rdata !== rline) begin
            mismatched++; $display("[TB] FAIL wrong_cpl_then_ready: got %b/%b %h expected 0010/0 %h", done, err, rdata, rline);
        end
        tick();
    endtask

    task automatic test_timeout;
        logic [DW-1:0] word;
        word = $urandom;
        doReset();
        reqWrite = 4'b1000;
        reqWdata[3] = word;
        tick();
        compared++;
        if ({l2ReadReq, l2WriteReq, l2WbReq} !== 3'b010 || l2Wdata !== word) begin
            mismatched++; $display("[TB] FAIL tmo_issue: got l2req %b wdata %h expected 010 %h", {l2ReadReq, l2WriteReq, l2WbReq}, l2Wdata, word);
        end
        repeat (TMO - 1) tick();
        compared++;
        if (done !== 4'b0000 || {l2ReadReq, l2WriteReq, l2WbReq} !== 3'b010) begin
            mismatched++; $display("[TB] FAIL tmo_early: got done %b l2req %b expected 0000/010", done, {l2ReadReq, l2WriteReq, l2WbReq});
        end
        tick();
        reqWrite = '0;
        compared++;
        if (done !== 4'b1000 || err !== 1'b1 || {l2ReadReq, l2WriteReq, l2WbReq} !== 3'b000) begin
            mismatched++; $display("[TB] FAIL tmo_abort: got done %b err %b l2req %b expected 1000/1/000", done, err, {l2ReadReq, l2WriteReq, l2WbReq});
        end
        tick();
        compared++;
        if (done !== 4'b0000 || err !== 1'b0 || gnt !== 4'b0000) begin
            mismatched++; $display("[TB] FAIL tmo_pulse_width: got done %b err %b gnt %b expected 0000/0/0000", done, err, gnt);
        end
    endtask

    task automatic test_reset_mid_busy;
        doReset();
        reqRead = 4'b0100;
        reqAddr[2] = $urandom;
        tick();
        compared++;
        if (gnt !== 4'b0100) begin mismatched++; $display("[TB] FAIL midrst_grant: got %b expected 0100", gnt); end
        tick();
        #2;
        reset = 1'b1;
        #1;
        compared++;
        if (gnt !== '0 || done !== '0 || err !== 1'b0 || {l2ReadReq, l2WriteReq, l2WbReq} !== 3'b000 || l2Addr !== '0) begin
            mismatched++; $display("[TB] FAIL midrst_clear: got gnt %b done %b err %b l2req %b addr %h expected zeros", gnt, done, err, {l2ReadReq, l2WriteReq, l2WbReq}, l2Addr);
        end
        tick();
        reqRead = 4'b0101;
        reset = 1'b0;
        tick();
        compared++;
        if (gnt !== 4'b0001 || done !== 4'b0000) begin mismatched++; $display("[TB] FAIL midrst_next_grant: got gnt %b done %b expected 0001/0000", gnt, done); end
        l2Ready = 1'b1;
        tick();
        l2Ready = 1'b0;
        reqRead = '0;
        tick();
    endtask

    // Reference model: round-robin from the last served index, priority WB > WRITE > READ.
    task automatic test_random;
        int modelLast, expWin, c, nWait;
        bit doTimeout;
        logic [NREQ-1:0] elig, expGnt;
        logic [2:0] expOp;
        logic [AW-1:0] expAddr;
        logic [DW-1:0] expWdata;
        logic [MW-1:0] expWbdata, modelRdata, line;
        doReset();
        modelLast = NREQ - 1;
        modelRdata = '0;
        for (int t = 0; t < 40; t++) begin
            reqRead  = 4'($urandom);
            reqWrite = 4'($urandom) & 4'($urandom);
            reqWb    = 4'($urandom) & 4'($urandom);
            if ((reqRead | reqWrite | reqWb) == 4'b0000) reqRead = 4'b0001 << $urandom_range(NREQ - 1);
            for (int k = 0; k < NREQ; k++) begin
                reqAddr[k] = $urandom;
                reqWdata[k] = $urandom;
                reqWbdata[k] = {$urandom, $urandom, $urandom, $urandom};
            end
            elig = reqRead | reqWrite | reqWb;
            expWin = -1;
            for (int s = 1; s <= NREQ; s++) begin
                c = (modelLast + s) % NREQ;
                if (expWin < 0 && elig[c]) expWin = c;
            end
            expGnt = 4'b0001 << expWin;
            expOp = reqWb[expWin] ? 3'b001 : (reqWrite[expWin] ? 3'b010 : 3'b100);
            expAddr = reqAddr[expWin];
            expWdata = reqWdata[expWin];
            expWbdata = reqWbdata[expWin];
            tick();
            compared++;
            if (gnt !== expGnt || {l2ReadReq, l2WriteReq, l2WbReq} !== expOp) begin
                mismatched++; $display("[TB] FAIL rand_grant_%0d: got gnt %b l2req %b expected %b/%b", t, gnt, {l2ReadReq, l2WriteReq, l2WbReq}, expGnt, expOp);
            end
            for (int k = 0; k < NREQ; k++) reqAddr[k] = $urandom;
            doTimeout = ($urandom_range(5) == 0);
            nWait = doTimeout ? (TMO - 1) : $urandom_range(5);
            for (int w = 0; w <= nWait; w++) begin
                l2Ready = (expOp != 3'b100) ? 1'($urandom) : 1'b0;
                l2WriteVerified = (expOp != 3'b010) ? 1'($urandom) : 1'b0;
                l2WbVerified = (expOp != 3'b001) ? 1'($urandom) : 1'b0;
                l2Rdata = {$urandom, $urandom, $urandom, $urandom};
                if (w == nWait && !doTimeout) begin
                    l2Ready = expOp[2];
                    l2WriteVerified = expOp[1];
                    l2WbVerified = expOp[0];
                end
                line = l2Rdata;
                tick();
                if (w < nWait) begin
                    compared++;
                    if (done !== 4'b0000 || l2Addr !== expAddr) begin
                        mismatched++; $display("[TB] FAIL rand_wait_%0d_%0d: got done %b addr %h expected 0000 %h", t, w, done, l2Addr, expAddr);
                    end
                    compared++;
                    if ((expOp == 3'b010 && l2Wdata !== expWdata) || (expOp == 3'b001 && l2Wbdata !== expWbdata)) begin
                        mismatched++; $display("[TB] FAIL rand_payload_%0d: got %h/%h expected %h/%h", t, l2Wdata, l2Wbdata, expWdata, expWbdata);
                    end
                end
            end
            if (!doTimeout && expOp == 3'b100) modelRdata = line;
            modelLast = expWin;
            l2Ready = 1'b0; l2WriteVerified = 1'b0; l2WbVerified = 1'b0;
            compared++;
            if (done !== expGnt || err !== doTimeout || {l2ReadReq, l2WriteReq, l2WbReq} !== 3'b000) begin
                mismatched++; $display("[TB] FAIL rand_done_%0d: got done %b err %b l2req %b expected %b/%b/000", t, done, err, {l2ReadReq, l2WriteReq, l2WbReq}, expGnt, doTimeout);
            end
            compared++;
            if (rdata !== modelRdata) begin mismatched++; $display("[TB] FAIL rand_rdata_%0d: got %h expected %h", t, rdata, modelRdata); end
            reqRead = '0; reqWrite = '0; reqWb = '0;
            tick();
            compared++;
            if (gnt !== 4'b0000 || done !== 4'b0000) begin mismatched++; $display("[TB] FAIL rand_release_%0d: got gnt %b done %b expected 0000/0000", t, gnt, done); end
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        clearInputs();
        test_reset();
        test_read_basic();
        test_round_robin();
        test_priority();
        test_wrong_completion();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
